// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle adder; iterates a DIGIT-bit full-adder slice over
//            WIDTH-bit operands with a start/busy/done handshake.
//            Optional subtract mode when SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outS,
    output logic             Cout,
    output logic             ovf
);

    localparam int c_n_slices = WIDTH / DIGIT;
    localparam int c_cnt_w    = (c_n_slices > 1) ? $clog2(c_n_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n_slices - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_inv;
    logic               w_start_inv;
    logic [DIGIT-1:0]   w_b;
    logic [DIGIT-1:0]   w_s;
    logic [DIGIT:0]     w_c;
    logic [WIDTH-1:0]   w_psum_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic r_sub;
    assign w_inv       = r_sub;
    assign w_start_inv = sub;
`else
    assign w_inv       = 1'b0;
    assign w_start_inv = 1'b0;
`endif

    // Ripple the slice bit by bit; w_c[DIGIT-1] is the carry into the slice MSB.
    always_comb begin
        logic [DIGIT:0] c;
        w_b  = r_b[DIGIT-1:0] ^ {DIGIT{w_inv}};
        w_s  = '0;
        c    = '0;
        c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_s[i]   = r_a[i] ^ w_b[i] ^ c[i];
            c[i+1]   = (r_a[i] & w_b[i]) | (c[i] & (r_a[i] ^ w_b[i]));
        end
        w_c = c;
    end

    // Slice sum enters at the top; after N slices the word is aligned.
    assign w_psum_next = (r_psum >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            outS    <= '0;
            Cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= inA;
                        r_b     <= inB;
                        r_carry <= Cin ^ w_start_inv;
                        r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        r_sub   <= sub;
`endif
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_psum  <= w_psum_next;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        outS    <= w_psum_next;
                        Cout    <= w_c[DIGIT];
                        ovf     <= w_c[DIGIT] ^ w_c[DIGIT-1];
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (DIGIT=1 and DIGIT=4 builds),
//            directed vectors plus random operations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start4;
    logic [7:0] inA, inB;
    logic       Cin;
    logic       sub;
    logic       busy1, done1, Cout1, ovf1;
    logic       busy4, done4, Cout4, ovf4;
    logic [7:0] outS1, outS4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .inA(inA), .inB(inB), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .outS(outS1), .Cout(Cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .inA(inA), .inB(inB), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy4), .done(done4), .outS(outS4), .Cout(Cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One operation on the selected DUT, checked against plain arithmetic.
    task automatic run_op(input bit use4, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input bit do_hold,
                          output logic [7:0] s_o, output logic c_o, output logic v_o);
        int n, lat, bcnt;
        logic [7:0] bb;
        logic [8:0] r;
        logic       ov;
        n   = use4 ? 2 : 8;
        bb  = sb ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {8'd0, (sb ? ~ci : ci)};
        ov  = (a[7] == bb[7]) && (r[7] != a[7]);
        s_o = 8'hxx; c_o = 1'bx; v_o = 1'bx;
        @(negedge clk);
        inA = a; inB = b; Cin = ci; sub = sb;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        lat = 0; bcnt = 0;
        for (int t = 1; t <= n + 3; t++) begin
            if (t > 1) @(negedge clk);
            if (use4 ? busy4 : busy1) bcnt++;
            if ((use4 ? done4 : done1) && lat == 0) begin
                lat = t;
                s_o = use4 ? outS4 : outS1;
                c_o = use4 ? Cout4 : Cout1;
                v_o = use4 ? ovf4  : ovf1;
            end
        end
        chk("latency", lat, n + 1);
        chk("busy_cycles", bcnt, n);
        chk("sum", {24'd0, s_o}, {24'd0, r[7:0]});
        chk("cout", {31'd0, c_o}, {31'd0, r[8]});
        chk("ovf", {31'd0, v_o}, {31'd0, ov});
        if (do_hold) chk("hold_sum", {24'd0, (use4 ? outS4 : outS1)}, {24'd0, r[7:0]});
    endtask

    initial begin
        logic [7:0] s;
        logic       c, v;
        int t1, t2, dcnt;
        logic [7:0] s1, s2;

        rst_n = 1'b0; start1 = 1'b1; start4 = 1'b1;
        inA = 8'h12; inB = 8'h34; Cin = 1'b1; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", {30'd0, busy1, busy4}, 32'd0);
            chk("rst_done", {30'd0, done1, done4}, 32'd0);
            chk("rst_out", {outS1, outS4, Cout1, ovf1, Cout4, ovf4}, 32'd0);
        end
        start1 = 1'b0; start4 = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b1, s, c, v);
        chk("d_5a_a5", {s, c, v}, {8'h00, 1'b1, 1'b0});
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, s, c, v);
        chk("d_7f_01", {s, c, v}, {8'h80, 1'b0, 1'b1});
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, s, c, v);
        chk("d_ff_01", {s, c, v}, {8'h00, 1'b1, 1'b0});
        run_op(1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b1, s, c, v);
        chk("d4_99_99", {s, c}, {8'h32, 1'b1});
        if (SUB_EN) begin
            run_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, s, c, v);
            chk("sub_10_20", {s, c}, {8'hF0, 1'b0});
            run_op(1'b1, 8'h20, 8'h10, 1'b1, 1'b1, 1'b0, s, c, v);
            chk("sub_20_10", {s, c}, {8'h0F, 1'b1});
            run_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, s, c, v);
            chk("sub_80_01", {s, v}, {8'h7F, 1'b1});
        end

        // Start held high through RUN and into DONE: back-to-back operations.
        @(negedge clk);
        inA = 8'h03; inB = 8'h04; Cin = 1'b0; sub = 1'b0; start1 = 1'b1;
        @(negedge clk);
        inA = 8'hF0; inB = 8'h0F;
        t1 = 0; t2 = 0; s1 = 8'h00; s2 = 8'h00;
        for (int t = 1; t <= 22; t++) begin
            if (t > 1) @(negedge clk);
            if (done1) begin
                if (t1 == 0) begin t1 = t; s1 = outS1; end
                else if (t2 == 0) begin t2 = t; s2 = outS1; start1 = 1'b0; end
            end
        end
        start1 = 1'b0;
        chk("hs_t1", t1, 9);
        chk("hs_s1", {24'd0, s1}, 32'h07);
        chk("hs_t2", t2, 18);
        chk("hs_s2", {24'd0, s2}, 32'hFF);

        // Reset during RUN abandons the operation without a done pulse.
        @(negedge clk);
        inA = 8'h11; inB = 8'h22; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_busy", {31'd0, busy1}, 32'd0);
        chk("mr_out", {22'd0, outS1, Cout1, ovf1}, 32'd0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        chk("mr_no_done", dcnt, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc, rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            run_op(1'(i % 2), ra, rb, rc, rs, 1'b0, s, c, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
